// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a requester and the apb4_mem_slave completer.
// Clock and reset are deliberately kept outside as plain ports.
interface apb4_mem_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_mem_slave.sv
// Parametrised APB4 memory completer with programmable wait states,
// byte-lane write strobes and error response for bad addresses.
//
// state  | meaning
// IDLE   | waiting for a setup phase (PSEL=1, PENABLE=0)
// ACCESS | transfer latched; counting wait states, completes when counter hits 0
module apb4_mem_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb4_mem_slave_if.slave   apb
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic [ADDR_WIDTH-1:0] addr_idx;
    logic                  addr_err;

    // Full-width compare so DEPTH == 2**ADDR_WIDTH does not wrap to zero.
    assign addr_idx = apb.PADDR >> OFF;
    assign addr_err = ((apb.PADDR & ADDR_WIDTH'(NB - 1)) != '0)
                   || ({1'b0, addr_idx} >= (ADDR_WIDTH + 1)'(DEPTH));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        err_d    = err_q;
        wr_d     = wr_q;
        prdata_d = prdata_q;
        mem_d    = mem_q;
        case (state_q)
            IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    idx_d    = addr_idx[IW-1:0];
                    err_d    = addr_err;
                    wr_d     = apb.PWRITE;
                    cnt_d    = 4'(WAIT_STATES);
                    prdata_d = (!apb.PWRITE && !addr_err) ? mem_q[addr_idx[IW-1:0]] : '0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!apb.PSEL || !apb.PENABLE) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (wr_q && !err_q) begin
                        for (int i = 0; i < NB; i++) begin
                            if (apb.PSTRB[i]) mem_d[idx_q][8*i +: 8] = apb.PWDATA[8*i +: 8];
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            prdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            prdata_q <= prdata_d;
            mem_q    <= mem_d;
        end
    end

    assign apb.PRDATA  = prdata_q;
    assign apb.PREADY  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign apb.PSLVERR = apb.PREADY && err_q;
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: one instance with no wait states, one with three,
// both compared against a word-array model of the memory.
module tb_apb4_mem_slave;
    localparam int AW = 9;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          psel0 = 1'b0, psel3 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;

    apb4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
    apb4_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus3 ();

    assign bus0.PSEL = psel0;   assign bus3.PSEL = psel3;
    assign bus0.PENABLE = penable; assign bus3.PENABLE = penable;
    assign bus0.PWRITE = pwrite;   assign bus3.PWRITE = pwrite;
    assign bus0.PADDR = paddr;     assign bus3.PADDR = paddr;
    assign bus0.PWDATA = pwdata;   assign bus3.PWDATA = pwdata;
    assign bus0.PSTRB = pstrb;     assign bus3.PSTRB = pstrb;

    apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus0.slave));
    apb4_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .PCLK(clk), .PRESETn(rst_n), .apb(bus3.slave));

    int tests = 0;
    int fails = 0;

    logic [31:0] mdl [2][64];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 64; i++) mdl[d][i] = 32'h0;
    endtask

    task automatic outs(input int w, output logic rdy, output logic err, output logic [31:0] rd);
        if (w == 0) begin rdy = bus0.PREADY; err = bus0.PSLVERR; rd = bus0.PRDATA; end
        else        begin rdy = bus3.PREADY; err = bus3.PSLVERR; rd = bus3.PRDATA; end
    endtask

    task automatic set_sel(input int w, input logic v);
        if (w == 0) psel0 = v; else psel3 = v;
    endtask

    task automatic go_idle();
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    // Entered and left at posedge+1; PSEL stays high so transfers can chain.
    task automatic xfer(input int w, input logic wr, input logic [AW-1:0] addr,
                        input logic [31:0] wd, input logic [3:0] sb, input string tag,
                        output logic [31:0] rd_out);
        int ws, n, idx;
        logic bad, rdy, err, stable;
        logic [31:0] rd, first, exp_rd;
        ws  = (w == 0) ? 0 : 3;
        idx = int'(addr) / 4;
        bad = (addr % 4 != 0) || (idx >= 64);
        exp_rd = (!wr && !bad) ? mdl[w][idx] : 32'h0;
        go_idle();
        set_sel(w, 1'b1);
        pwrite = wr; paddr = addr; pwdata = wd; pstrb = sb;
        @(posedge clk); #1;
        penable = 1'b1;
        // Garbage on address/direction during ACCESS must be ignored.
        paddr = AW'($urandom); pwrite = ~wr;
        outs(w, rdy, err, first);
        stable = 1'b1; n = 0;
        while (!rdy && n < 40) begin
            if (err !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
            n++;
            outs(w, rdy, err, rd);
            if (rd !== first) stable = 1'b0;
        end
        outs(w, rdy, err, rd);
        chk({tag, "_ready_waits"}, 64'(n), 64'(ws));
        chk({tag, "_pslverr"}, {63'h0, err}, {63'h0, bad});
        if (!wr) begin
            chk({tag, "_prdata"}, {32'h0, rd}, {32'h0, exp_rd});
            chk({tag, "_prdata_stable"}, {63'h0, stable}, 64'h1);
        end
        rd_out = rd;
        if (wr && !bad)
            for (int i = 0; i < 4; i++)
                if (sb[i]) mdl[w][idx][8*i +: 8] = wd[8*i +: 8];
        @(posedge clk); #1;
    endtask

    logic [31:0] rdv;
    logic        r_rdy, r_err;
    logic [31:0] r_rd;
    int          t0;

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < 4; w += 3) begin
            outs(w, r_rdy, r_err, r_rd);
            chk("rst_prdata", {32'h0, r_rd}, 64'h0);
            chk("rst_pready", {63'h0, r_rdy}, 64'h0);
            chk("rst_pslverr", {63'h0, r_err}, 64'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "rd_after_rst", rdv);
        chk("rd_after_rst_val", {32'h0, rdv}, 64'h0);

        t0 = cyc;
        xfer(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, "wr_full", rdv);
        chk("wr_full_cycles", 64'(cyc - t0), 64'd2);
        go_idle();
        t0 = cyc;
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "rd_full", rdv);
        chk("rd_full_cycles", 64'(cyc - t0), 64'd2);
        chk("rd_full_val", {32'h0, rdv}, 64'hDEADBEEF);

        xfer(0, 1'b1, 9'h010, 32'h11223344, 4'b0101, "wr_strb", rdv);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "rd_strb", rdv);
        chk("strb_merge", {32'h0, rdv}, 64'hDE22BE44);
        xfer(0, 1'b1, 9'h010, 32'hFFFFFFFF, 4'h0, "wr_nostrb", rdv);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "rd_nostrb", rdv);
        go_idle();

        xfer(3, 1'b1, 9'h020, 32'hAABBCCDD, 4'hF, "ws3_wr", rdv);
        go_idle();
        t0 = cyc;
        xfer(3, 1'b0, 9'h020, 32'h0, 4'h0, "ws3_rd", rdv);
        chk("ws3_rd_cycles", 64'(cyc - t0), 64'd5);
        chk("ws3_rd_val", {32'h0, rdv}, 64'hAABBCCDD);
        go_idle();

        xfer(0, 1'b1, 9'h100, 32'h12345678, 4'hF, "err_oob_wr", rdv);
        xfer(0, 1'b0, 9'h012, 32'h0, 4'h0, "err_mis_rd", rdv);
        xfer(0, 1'b1, 9'h012, 32'h55555555, 4'hF, "err_mis_wr", rdv);
        xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, "err_unchanged", rdv);
        chk("err_mem_kept", {32'h0, rdv}, 64'hDE22BE44);
        go_idle();

        // Abort a WAIT_STATES=3 write after one access cycle.
        psel3 = 1'b1; pwrite = 1'b1; paddr = 9'h020; pwdata = 32'h01010101; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        outs(3, r_rdy, r_err, r_rd);
        chk("abort_no_ready", {63'h0, r_rdy}, 64'h0);
        go_idle();
        @(posedge clk); #1;
        outs(3, r_rdy, r_err, r_rd);
        chk("abort_idle_ready", {63'h0, r_rdy}, 64'h0);
        xfer(3, 1'b0, 9'h020, 32'h0, 4'h0, "abort_rd", rdv);
        chk("abort_mem_kept", {32'h0, rdv}, 64'hAABBCCDD);
        go_idle();
        @(posedge clk); #1;

        for (int w = 0; w < 4; w += 3) begin
            t0 = cyc;
            xfer(w, 1'b1, 9'h030, 32'hCAFE0000 | 32'(w), 4'hF, "b2b_w0", rdv);
            xfer(w, 1'b1, 9'h034, 32'h0BADF00D, 4'hF, "b2b_w1", rdv);
            xfer(w, 1'b0, 9'h030, 32'h0, 4'h0, "b2b_r0", rdv);
            chk("b2b_r0_val", {32'h0, rdv}, {32'h0, 32'hCAFE0000 | 32'(w)});
            xfer(w, 1'b0, 9'h034, 32'h0, 4'h0, "b2b_r1", rdv);
            chk("b2b_r1_val", {32'h0, rdv}, 64'h0BADF00D);
            chk("b2b_cycles", 64'(cyc - t0), 64'(4 * (((w == 0) ? 0 : 3) + 2)));
            go_idle();
        end

        // PENABLE without a preceding setup phase must be ignored.
        @(posedge clk); #1;
        psel0 = 1'b1; penable = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            outs(0, r_rdy, r_err, r_rd);
            chk("penable_idle_ready", {63'h0, r_rdy}, 64'h0);
        end
        go_idle();
        @(posedge clk); #1;

        for (int k = 0; k < 60; k++) begin
            int w;
            logic [AW-1:0] a;
            w = (k % 2 == 0) ? 0 : 3;
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15) * 4);
            xfer(w, 1'(($urandom)), a, $urandom, 4'($urandom), "rand", rdv);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
        @(posedge clk); #1;

        // Reset in the middle of a WAIT_STATES=3 transfer.
        psel3 = 1'b1; pwrite = 1'b1; paddr = 9'h020; pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        outs(3, r_rdy, r_err, r_rd);
        chk("midrst_pready", {63'h0, r_rdy}, 64'h0);
        chk("midrst_prdata", {32'h0, r_rd}, 64'h0);
        go_idle();
        clear_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        xfer(3, 1'b0, 9'h020, 32'h0, 4'h0, "midrst_rd", rdv);
        go_idle();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
